// File: rtl/alu_decode_stage_pkg.sv
// Package shared by the ALU decode stage.
// Holds the alu_sel encodings, the zero/ADD label constant and the
// occupancy states of the two-entry skid buffer.
package alu_decode_stage_pkg;

    // Decode modes carried on alu_sel
    typedef enum logic [1:0] {
        SEL_ADD   = 2'b00,
        SEL_RTYPE = 2'b01,
        SEL_FUNCT = 2'b10,
        SEL_RSVD  = 2'b11
    } alu_sel_e;

    // The ADD operation is encoded as all zeros; wide enough for any label
    // width, sliced down by the user.
    localparam logic [31:0] LABEL_ADD = 32'h0000_0000;

    // Occupancy of the main/skid register pair
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_MAIN  = 2'b01,
        BUF_FULL  = 2'b10
    } buf_state_e;

endpackage

// File: rtl/alu_decode_stage_label_decode.sv
// alu_label_decode: purely combinational translation of alu_sel/instr into
// an ALU operation label plus an illegal-select flag.
// Ports:
//   alu_sel  in   decode mode (see alu_sel_e)
//   instr    in   instruction word
//   label    out  ALU operation label
//   illegal  out  high when alu_sel is the reserved encoding
module alu_label_decode #(
    parameter int INSTR_W   = 16,
    parameter int LABEL_W   = 4,
    parameter int RTYPE_LSB = 9
) (
    input  logic [1:0]         alu_sel,
    input  logic [INSTR_W-1:0] instr,
    output logic [LABEL_W-1:0] label,
    output logic               illegal
);
    import alu_decode_stage_pkg::*;

    // Defaults first so the reserved encoding still drives every output
    // (zero label) and nothing can latch.
    always_comb begin
        label   = LABEL_ADD[LABEL_W-1:0];
        illegal = 1'b0;
        case (alu_sel_e'(alu_sel))
            SEL_ADD:   label = LABEL_ADD[LABEL_W-1:0];
            SEL_RTYPE: label = instr[RTYPE_LSB+LABEL_W-1:RTYPE_LSB];
            // Function field is one bit narrower than the label; the
            // label LSB is always zero in this mode.
            SEL_FUNCT: label = {instr[LABEL_W-2:0], 1'b0};
            SEL_RSVD:  illegal = 1'b1;
            default:   ;
        endcase
    end

endmodule

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: decodes an instruction word into a registered ALU
// operation label behind a two-entry skid buffer (main + skid register).
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   in_valid / in_ready    upstream handshake (in_ready = skid empty)
//   instr, alu_sel         instruction word and decode mode
//   flush                  discard everything held, drop the current input
//   out_valid / out_ready  downstream handshake
//   label, illegal         registered decode result of the main entry
//   illegal_cnt            saturating count of accepted reserved selects
module alu_decode_stage #(
    parameter int INSTR_W   = 16,
    parameter int LABEL_W   = 4,
    parameter int RTYPE_LSB = 9,
    parameter int CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic [1:0]         alu_sel,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LABEL_W-1:0] label,
    output logic               illegal,
    output logic [CNT_W-1:0]   illegal_cnt
);
    import alu_decode_stage_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    buf_state_e         state;
    buf_state_e         state_next;
    logic [LABEL_W-1:0] dec_label;
    logic               dec_illegal;
    logic [LABEL_W-1:0] main_label;
    logic               main_illegal;
    logic [LABEL_W-1:0] skid_label;
    logic               skid_illegal;
    logic               in_xfer;
    logic               out_xfer;
    logic               load_main_dec;
    logic               load_main_skid;
    logic               load_skid;
    logic               clear_all;

    alu_label_decode #(
        .INSTR_W   (INSTR_W),
        .LABEL_W   (LABEL_W),
        .RTYPE_LSB (RTYPE_LSB)
    ) u_decode (
        .alu_sel (alu_sel),
        .instr   (instr),
        .label   (dec_label),
        .illegal (dec_illegal)
    );

    // Handshake flags come straight from the registered occupancy state.
    assign out_valid = (state != BUF_EMPTY);
    assign in_ready  = (state != BUF_FULL);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign label     = main_label;
    assign illegal   = main_illegal;

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BUF_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and register-load decisions. A word only ever enters the
    // skid when main is held by a stalled downstream; the skid then drains
    // into main on the next output transfer, keeping acceptance order.
    always_comb begin
        state_next     = state;
        load_main_dec  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        clear_all      = 1'b0;
        if (flush) begin
            state_next = BUF_EMPTY;
            clear_all  = 1'b1;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    if (in_xfer) begin
                        state_next    = BUF_MAIN;
                        load_main_dec = 1'b1;
                    end
                end
                BUF_MAIN: begin
                    if (in_xfer && out_xfer) begin
                        load_main_dec = 1'b1;
                    end else if (in_xfer) begin
                        state_next = BUF_FULL;
                        load_skid  = 1'b1;
                    end else if (out_xfer) begin
                        state_next = BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (out_xfer) begin
                        state_next     = BUF_MAIN;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_next = BUF_EMPTY;
            endcase
        end
    end

    // Main and skid data registers. Flush zeroes them so label/illegal
    // read as zero while nothing is held.
    always_ff @(posedge clk) begin
        if (rst || clear_all) begin
            main_label   <= '0;
            main_illegal <= 1'b0;
            skid_label   <= '0;
            skid_illegal <= 1'b0;
        end else begin
            if (load_main_dec) begin
                main_label   <= dec_label;
                main_illegal <= dec_illegal;
            end else if (load_main_skid) begin
                main_label   <= skid_label;
                main_illegal <= skid_illegal;
            end
            if (load_skid) begin
                skid_label   <= dec_label;
                skid_illegal <= dec_illegal;
            end
        end
    end

    // Saturating counter of accepted reserved-select words; words dropped
    // by a flush are not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (in_xfer && dec_illegal && !flush && (illegal_cnt != CNT_MAX)) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed testbench for alu_decode_stage. A second instance with a 2-bit
// counter sees the same traffic to exercise counter saturation.
module tb_alu_decode_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic [1:0]  alu_sel;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  label;
    logic        illegal;
    logic [7:0]  illegal_cnt;

    logic        in_ready_c2;
    logic        out_valid_c2;
    logic [3:0]  label_c2;
    logic        illegal_c2;
    logic [1:0]  illegal_cnt_c2;

    int checks = 0;
    int errors = 0;

    alu_decode_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .alu_sel     (alu_sel),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .label       (label),
        .illegal     (illegal),
        .illegal_cnt (illegal_cnt)
    );

    alu_decode_stage #(.CNT_W(2)) dut_c2 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready_c2),
        .instr       (instr),
        .alu_sel     (alu_sel),
        .flush       (flush),
        .out_valid   (out_valid_c2),
        .out_ready   (out_ready),
        .label       (label_c2),
        .illegal     (illegal_c2),
        .illegal_cnt (illegal_cnt_c2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then read 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        alu_sel   = 2'b00;
        instr     = 16'h0000;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid got %0h expected 0", out_valid);
        end
        checks++;
        if (label !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_label got %0h expected 0", label);
        end
        checks++;
        if (illegal !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_illegal got %0h expected 0", illegal);
        end
        checks++;
        if (illegal_cnt !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_cnt got %0h expected 0", illegal_cnt);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready got %0h expected 1", in_ready);
        end
    endtask

    // Back-to-back words in every decode mode with downstream always ready.
    task automatic test_decode();
        do_reset();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        instr     = 16'h1A05;
        alu_sel   = 2'b01;
        tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rtype_out_valid got %0h expected 1", out_valid);
        end
        checks++;
        if (label !== 4'hD) begin
            errors++;
            $display("[TB] FAIL rtype_label got %0h expected d", label);
        end
        checks++;
        if (illegal !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rtype_illegal got %0h expected 0", illegal);
        end
        alu_sel = 2'b10;
        tick();
        checks++;
        if (label !== 4'hA) begin
            errors++;
            $display("[TB] FAIL funct_label got %0h expected a", label);
        end
        alu_sel = 2'b00;
        tick();
        checks++;
        if (label !== 4'h0 || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL add_label got %0h/%0h expected 0/1", label, out_valid);
        end
        alu_sel = 2'b11;
        tick();
        checks++;
        if (label !== 4'h0 || illegal !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rsvd_label got %0h/%0h expected 0/1", label, illegal);
        end
        checks++;
        if (illegal_cnt !== 8'd1) begin
            errors++;
            $display("[TB] FAIL rsvd_cnt got %0d expected 1", illegal_cnt);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drain_out_valid got %0h expected 0", out_valid);
        end
    endtask

    // Four words with downstream stalled on cycles 2-3.
    task automatic test_skid();
        logic [3:0] recv[$];
        int ptr;
        bit exp_rdy[8];
        bit oreq[8];
        exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        oreq    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        ptr = 0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            in_valid  = (ptr < 4);
            alu_sel   = 2'b10;
            instr     = 16'(ptr + 1);
            out_ready = oreq[c];
            if (out_valid && out_ready) recv.push_back(label);
            if (c == 1 || c == 2) begin
                checks++;
                if (label !== 4'h2 || out_valid !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL stall_hold cyc %0d got %0h/%0h expected 2/1", c, label, out_valid);
                end
            end
            if (in_valid && in_ready) ptr++;
            tick();
            checks++;
            if (in_ready !== exp_rdy[c]) begin
                errors++;
                $display("[TB] FAIL skid_in_ready cyc %0d got %0h expected %0h", c, in_ready, exp_rdy[c]);
            end
        end
        checks++;
        if (recv.size() != 4) begin
            errors++;
            $display("[TB] FAIL skid_count got %0d expected 4", recv.size());
        end
        for (int i = 0; i < recv.size() && i < 4; i++) begin
            checks++;
            if (recv[i] !== 4'(2 * (i + 1))) begin
                errors++;
                $display("[TB] FAIL skid_order idx %0d got %0h expected %0h", i, recv[i], 2 * (i + 1));
            end
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL skid_empty got %0h expected 0", out_valid);
        end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        alu_sel   = 2'b10;
        instr     = 16'h0001;
        tick();
        instr = 16'h0002;
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_pre_full got %0h expected 0", in_ready);
        end
        flush   = 1'b1;
        alu_sel = 2'b11;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_full got %0h/%0h expected 0/1", out_valid, in_ready);
        end
        checks++;
        if (label !== 4'h0 || illegal !== 1'b0 || illegal_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL flush_full_regs got %0h/%0h/%0h expected 0/0/0", label, illegal, illegal_cnt);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_no_ghost got %0h expected 0", out_valid);
        end
        // Main only: input is accepted-looking (in_ready=1) but must be dropped.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        alu_sel   = 2'b10;
        instr     = 16'h0005;
        tick();
        flush   = 1'b1;
        alu_sel = 2'b11;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || illegal_cnt !== 8'd0 || illegal_cnt_c2 !== 2'd0) begin
            errors++;
            $display("[TB] FAIL flush_drop got %0h/%0h/%0h expected 0/0/0", out_valid, illegal_cnt, illegal_cnt_c2);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_drop_ghost got %0h expected 0", out_valid);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] exp2[5];
        exp2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        alu_sel   = 2'b11;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (illegal_cnt_c2 !== exp2[i]) begin
                errors++;
                $display("[TB] FAIL sat_cnt2 word %0d got %0d expected %0d", i, illegal_cnt_c2, exp2[i]);
            end
            checks++;
            if (illegal_cnt !== 8'(i + 1) || illegal !== 1'b1) begin
                errors++;
                $display("[TB] FAIL sat_cnt8 word %0d got %0d/%0h expected %0d/1", i, illegal_cnt, illegal, i + 1);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_midstream();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        alu_sel   = 2'b11;
        tick();
        alu_sel = 2'b10;
        instr   = 16'h0005;
        tick();
        checks++;
        if (in_ready !== 1'b0 || illegal_cnt !== 8'd1) begin
            errors++;
            $display("[TB] FAIL midrst_pre got %0h/%0h expected 0/1", in_ready, illegal_cnt);
        end
        rst     = 1'b1;
        flush   = 1'b1;
        alu_sel = 2'b11;
        tick();
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_flags got %0h/%0h expected 0/1", out_valid, in_ready);
        end
        checks++;
        if (label !== 4'h0 || illegal !== 1'b0 || illegal_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL midrst_regs got %0h/%0h/%0h expected 0/0/0", label, illegal, illegal_cnt);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_lost got %0h expected 0", out_valid);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        alu_sel   = 2'b00;
        instr     = 16'h0000;
        test_reset();
        test_decode();
        test_skid();
        test_flush();
        test_saturate();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_decode_stage.md
ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 Parameter INSTR_W, default 16, instruction word width.
REQ-002 Parameter LABEL_W, default 4, ALU operation label width; function field width is LABEL_W-1.
REQ-003 Parameter RTYPE_LSB, default 9, LSB of the LABEL_W-bit R-type opcode field; field is instr[RTYPE_LSB+LABEL_W-1:RTYPE_LSB].
REQ-004 Parameter CNT_W, default 8, illegal-select counter width.
REQ-005 clk  input  1  single clock, rising-edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  upstream word valid.
REQ-008 in_ready  output  1  stage can accept a word this cycle.
REQ-009 instr  input  INSTR_W  instruction word.
REQ-010 alu_sel  input  2  decode mode: 00 pass-add, 01 R-type, 10 function-field, 11 reserved.
REQ-011 flush  input  1  discard held word (branch redirect).
REQ-012 out_valid  output  1  label valid downstream.
REQ-013 out_ready  input  1  downstream accepts.
REQ-014 label  output  LABEL_W  registered ALU operation code.
REQ-015 illegal  output  1  registered flag: held word had alu_sel 11.
REQ-016 illegal_cnt  output  CNT_W  saturating count of accepted alu_sel 11 words.

Function
REQ-017 Transfer in on in_valid && in_ready; transfer out on out_valid && out_ready.
REQ-018 Decode (combinational, then registered): 00 -> all zeros; 01 -> R-type field; 10 -> {instr[LABEL_W-2:0],1'b0}; 11 -> zeros with illegal=1.
REQ-019 No output ever holds an undriven/latched value for any alu_sel, including 11.
REQ-020 Two-entry skid buffer (main + skid register): in_ready = skid empty; full throughput of one word/cycle with out_ready high; latency 1 cycle from accept to out_valid.
REQ-021 When out_ready drops with main full and an input accepted, the new word goes to skid; skid drains into main on the next out transfer; in_ready deasserts while skid full.
REQ-022 Order preserved: words leave in acceptance order.
REQ-023 Simultaneous in-transfer and out-transfer with skid empty: main loads the new word, out_valid stays 1.
REQ-024 flush: next cycle main and skid empty, out_valid=0, label=0, illegal=0; an input presented in the flush cycle is dropped; illegal_cnt unaffected.
REQ-025 illegal_cnt increments by 1 per accepted alu_sel 11 word (not on flush-dropped words), saturates at 2^CNT_W-1, never wraps.
REQ-026 label and illegal hold stable while out_valid && !out_ready.

Reset
REQ-027 On rst (sampled at clk edge): out_valid=0, label=0, illegal=0, illegal_cnt=0, both buffer entries empty, in_ready=1 the following cycle.
REQ-028 rst overrides flush and any in-flight transfer; words held at reset are lost.

Structure
REQ-029 Shared package holds the alu_sel encodings (SEL_ADD, SEL_RTYPE, SEL_FUNCT, SEL_RSVD) and the zero/ADD label constant.
REQ-030 One sub-module, alu_label_decode: purely combinational alu_sel/instr -> {label, illegal}; instantiated once ahead of the skid buffer.

Verification
REQ-031 Reset then alu_sel=01, instr=16'h1A05, out_ready=1 -> next cycle out_valid=1, label=4'hD, illegal=0.
REQ-032 alu_sel=10, instr=16'h1A05 -> label=4'hA; alu_sel=00 -> label=4'h0; alu_sel=11 -> label=4'h0, illegal=1, illegal_cnt=1.
REQ-033 Stream 4 words with out_ready low on cycles 2-3 -> in_ready low exactly while skid full, all 4 labels delivered in order, none duplicated.
REQ-034 Flush with both entries full plus in_valid high -> next cycle out_valid=0, in_ready=1, dropped word never appears, illegal_cnt unchanged.
REQ-035 CNT_W=2, accept 5 alu_sel 11 words -> illegal_cnt reads 1,2,3,3,3.
REQ-036 Assert rst mid-stream with skid full -> next cycle all outputs at reset values, in_ready=1.
